axi_r_router: RTL
=================

Name: axi_r_router

Overview:
- Parametrised successor to the combinational R-channel decoder in the AXI interconnect.
- Arbitrates read-data bursts from NUM_SLV slave R channels (default slave included, as the last index) and holds the grant until the RLAST beat completes.
- Decodes the destination master from the upper RID bits and routes the beat to that master's R channel through a registered 2-entry skid stage.
- Gives full throughput, registered RREADY toward slaves, and detection of undecodable IDs.

Parameters:
- NUM_SLV, 3, number of slave R channels; index NUM_SLV-1 is the default/DECERR slave.
- NUM_MST, 2, number of master R channels.
- ID_BITS, 4, master-side RID width.
- IDS_BITS, 8, slave-side RID width; master index is RID[ID_BITS +: MW], where MW = max(1, $clog2(NUM_MST)) (localparam).
- DATA_BITS, 32, RDATA width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- RID_S  in  NUM_SLV*IDS_BITS  slave RIDs, slave i at [i*IDS_BITS +: IDS_BITS].
- RDATA_S  in  NUM_SLV*DATA_BITS  slave read data.
- RRESP_S  in  NUM_SLV*2  slave responses.
- RLAST_S  in  NUM_SLV  slave last flags.
- RVALID_S  in  NUM_SLV  slave valids.
- RREADY_S  out  NUM_SLV  readies to slaves.
- RID_M  out  NUM_MST*ID_BITS  master RIDs (upper bits stripped).
- RDATA_M  out  NUM_MST*DATA_BITS  master read data.
- RRESP_M  out  NUM_MST*2  master responses.
- RLAST_M  out  NUM_MST  master last flags.
- RVALID_M  out  NUM_MST  master valids.
- RREADY_M  in  NUM_MST  master readies.
- busy  out  1  a burst is granted.
- grant_idx  out  $clog2(NUM_SLV)  granted slave index; valid when busy.
- err_drop  out  1  one-cycle pulse when a beat with an out-of-range master index is discarded.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant_idx=0, skid empty. All RVALID_M/RREADY_S/busy/err_drop are 0; all RID_M/RDATA_M/RRESP_M/RLAST_M are 0.
- Reset mid-burst discards buffered beats; no partial beat is emitted after release.
- FSM IDLE:
  - If any RVALID_S, grant the first asserted index at or after rr_ptr, with wrap-around.
  - Latch grant_idx and go to BURST next cycle.
  - RREADY_S is all 0 in IDLE, so there is one bubble per burst.
- FSM BURST:
  - RREADY_S[grant_idx] = skid_in_ready; all other RREADY_S are 0.
  - A beat is accepted when RVALID_S[g] & RREADY_S[g].
  - Accepted beat with RLAST=1: next state IDLE, rr_ptr = (g+1) mod NUM_SLV.
  - A new request in that same cycle is considered in IDLE on the following cycle.
- busy = (state==BURST).
- Skid stage (sub-module):
  - 2 entries; skid_in_ready is registered (= not full).
  - Accepted beat appears on the master side the next cycle (latency 1).
  - Sustains 1 beat/cycle when the master holds RREADY.
  - Beat order is preserved.
- Output decode:
  - dest = head RID[ID_BITS +: MW].
  - RVALID_M[m] = head_valid & (dest==m); payload goes only to master m; other masters' payloads are 0.
  - RID_M[m] = head RID[ID_BITS-1:0].
  - Head pops on RREADY_M[dest].
- dest >= NUM_MST: head pops unconditionally in that cycle, no RVALID_M is asserted, and err_drop=1 for that cycle.
- Payload holds stable while RVALID_M=1 and RREADY_M=0; a master stall back-pressures to the slave within 2 beats.
- RRESP passes through unchanged, including DECERR from the default slave.

Decomposition:
- Shared package axi_pkg:
  - AXI width constants: ID, IDS, DATA, RESP widths.
  - RESP encodings OKAY/SLVERR/DECERR.
  - typedef r_beat_t struct packed {rid, rdata, rresp, rlast}.
  - function mst_idx(rid).
- Sub-module axi_r_skid: a 2-entry r_beat_t register slice with in_valid/in_ready/out_valid/out_ready. The router instantiates one.

Test Plan:
- Single burst: S0 sends 4 beats, RID=8'h13, RREADY_M1=1 -> M1 gets 4 beats, RID_M1=4'h3, first beat 2 cycles after RVALID_S0 rises; RLAST only on beat 4; M0 sees no RVALID.
- Round-robin: S0 and S1 both valid with 2-beat bursts, rr_ptr=0 -> S0 burst fully completes before S1; next contention grants S1 first.
- Lock: S1 asserts RVALID mid S0 burst -> RREADY_S1 stays 0 until the S0 RLAST beat is accepted; no interleaving at M0.
- Backpressure: RREADY_M0 low for 3 cycles mid-burst -> RREADY_S0 drops within 2 cycles; no beat lost or duplicated; data stable while stalled.
- Bad ID: NUM_MST=3, beat with RID[5:4]=2'b11 -> err_drop pulses 1 cycle; no RVALID_M; following beat delivered normally.
- Async reset during BURST with 2 beats buffered -> all RVALID_M and RREADY_S go 0 immediately; after release, state is IDLE and a fresh burst routes correctly.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-channel widths, response codes, beat type and the
// master-index helper used by the R-channel routing blocks.
package axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_IDS_W  = 8;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_IDS_W-1:0]  rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [AXI_RESP_W-1:0] rresp;
    logic                  rlast;
  } r_beat_t;

  typedef enum logic {ST_IDLE, ST_BURST} r_state_t;

  // Upper slave-side RID bits carry the originating master index.
  function automatic logic [AXI_IDS_W-AXI_ID_W-1:0] mst_idx(input logic [AXI_IDS_W-1:0] rid);
    return rid[AXI_IDS_W-1:AXI_ID_W];
  endfunction

endpackage

// File: rtl/axi_r_skid.sv
// 2-entry R-beat slice: in->out latency 1 cycle, one beat/cycle while out_ready holds.
// in_ready is a flop that drops once both entries are occupied, so upstream stalls within 2 beats.
module axi_r_skid import axi_pkg::*; #(
  parameter type T = r_beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T           r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic       r_in_rdy;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic       w_push;
  logic       w_pop;

  assign w_push    = in_valid & r_in_rdy;
  assign out_valid = (r_cnt != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign in_ready  = r_in_rdy;
  assign out_data  = r_mem[r_rptr];

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
      r_in_rdy <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= in_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_cnt    <= w_cnt_nxt;
      r_in_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/axi_r_router.sv
// Routes whole read bursts from NUM_SLV slaves to NUM_MST masters by upper RID bits; 1-cycle skid latency
// plus one arbitration bubble per burst. Master stalls reach the slave within 2 beats; bad-index beats drop.
module axi_r_router import axi_pkg::*; #(
  parameter int NUM_SLV   = 3,
  parameter int NUM_MST   = 2,
  parameter int ID_BITS   = AXI_ID_W,
  parameter int IDS_BITS  = AXI_IDS_W,
  parameter int DATA_BITS = AXI_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SLV*IDS_BITS-1:0]    RID_S,
  input  logic [NUM_SLV*DATA_BITS-1:0]   RDATA_S,
  input  logic [NUM_SLV*2-1:0]           RRESP_S,
  input  logic [NUM_SLV-1:0]             RLAST_S,
  input  logic [NUM_SLV-1:0]             RVALID_S,
  output logic [NUM_SLV-1:0]             RREADY_S,
  output logic [NUM_MST*ID_BITS-1:0]     RID_M,
  output logic [NUM_MST*DATA_BITS-1:0]   RDATA_M,
  output logic [NUM_MST*2-1:0]           RRESP_M,
  output logic [NUM_MST-1:0]             RLAST_M,
  output logic [NUM_MST-1:0]             RVALID_M,
  input  logic [NUM_MST-1:0]             RREADY_M,
  output logic                           busy,
  output logic [$clog2(NUM_SLV)-1:0]     grant_idx,
  output logic                           err_drop
);

  localparam int SW = $clog2(NUM_SLV);
  localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef struct packed {
    logic [IDS_BITS-1:0]   rid;
    logic [DATA_BITS-1:0]  rdata;
    logic [AXI_RESP_W-1:0] rresp;
    logic                  rlast;
  } beat_t;

  r_state_t      r_state, w_state_nxt;
  logic [SW-1:0] r_rr_ptr, w_rr_nxt;
  logic [SW-1:0] r_grant, w_grant_nxt;
  logic [SW-1:0] w_pick;
  beat_t         w_in_beat, w_head;
  logic          w_in_vld, w_skid_rdy, w_acc;
  logic          w_head_vld, w_out_rdy, w_bad;
  logic [MW-1:0] w_dest;
  logic          w_unused_rid;

  assign busy      = (r_state == ST_BURST);
  assign grant_idx = r_grant;
  assign w_acc     = w_in_vld & w_skid_rdy;

  // First requester at or after the round-robin pointer; lowest offset is written last and wins.
  always_comb begin
    w_pick = r_rr_ptr;
    for (int k = NUM_SLV-1; k >= 0; k--) begin
      if (RVALID_S[(int'(r_rr_ptr) + k) % NUM_SLV]) w_pick = SW'((int'(r_rr_ptr) + k) % NUM_SLV);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (|RVALID_S) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_acc && w_in_beat.rlast) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = (r_grant == SW'(NUM_SLV-1)) ? '0 : r_grant + SW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_beat = '0;
    w_in_vld  = 1'b0;
    RREADY_S  = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (r_grant == SW'(s)) begin
        w_in_beat.rid   = RID_S[s*IDS_BITS +: IDS_BITS];
        w_in_beat.rdata = RDATA_S[s*DATA_BITS +: DATA_BITS];
        w_in_beat.rresp = RRESP_S[s*2 +: 2];
        w_in_beat.rlast = RLAST_S[s];
        w_in_vld        = busy & RVALID_S[s];
        RREADY_S[s]     = busy & w_skid_rdy;
      end
    end
  end

  axi_r_skid #(.T(beat_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_vld),
    .in_ready  (w_skid_rdy),
    .in_data   (w_in_beat),
    .out_valid (w_head_vld),
    .out_ready (w_out_rdy),
    .out_data  (w_head)
  );

  assign w_dest       = w_head.rid[ID_BITS +: MW];
  assign w_unused_rid = ^w_head.rid;

  // An undecodable head has no master to wait for, so it pops at once.
  always_comb begin
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = '0;
    RLAST_M   = '0;
    RVALID_M  = '0;
    w_out_rdy = 1'b0;
    w_bad     = 1'b1;
    for (int m = 0; m < NUM_MST; m++) begin
      if (w_dest == MW'(m)) begin
        w_bad     = 1'b0;
        w_out_rdy = RREADY_M[m];
        if (w_head_vld) begin
          RVALID_M[m]                         = 1'b1;
          RID_M[m*ID_BITS +: ID_BITS]         = w_head.rid[ID_BITS-1:0];
          RDATA_M[m*DATA_BITS +: DATA_BITS]   = w_head.rdata;
          RRESP_M[m*2 +: 2]                   = w_head.rresp;
          RLAST_M[m]                          = w_head.rlast;
        end
      end
    end
    if (w_bad) w_out_rdy = 1'b1;
    err_drop = w_head_vld & w_bad;
  end

endmodule
